// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, latencies, FSM states and result math.
// Used by the MDU and by the controller that issues MDU-class instructions.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_SHL   = 3'd4;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Returns {HI,LO}; signed divide works on magnitudes, then fixes signs.
  function automatic logic [63:0] mdu_calc(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] sa, sb, res;
    logic [31:0] ma, mb, q, r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ma  = a[31] ? (~a + 32'd1) : a;
    mb  = b[31] ? (~b + 32'd1) : b;
    q   = 32'd0;
    r   = 32'd0;
    res = 64'd0;
    case (op)
      MDU_MULT:  res = sa * sb;
      MDU_MULTU: res = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        q = ma / mb;
        r = ma % mb;
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31]) r = ~r + 32'd1;
        res = {r, q};
      end
      MDU_DIVU:  res = {a % b, a / b};
      default:   res = 64'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Long ops run a fixed-latency count; shl and mthi/mtlo complete in IDLE.
module mdu_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        accept, done;
  logic [31:0] op_a, op_b;
  logic [2:0]  op_q;
  logic [63:0] res;
  logic        wr_ok;

  assign busy      = (state == MDU_RUN);
  assign stall_req = start | busy;
  assign res       = mdu_calc(op_q, op_a, op_b);
  assign wr_ok     = !(is_div(op_q) && (op_b == 32'd0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MDU_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state)
      MDU_IDLE: begin
        if (start && (op <= MDU_DIVU)) begin
          accept  = 1'b1;
          state_n = MDU_RUN;
          cnt_n   = is_div(op) ? DIV_CYCLES : MULT_CYCLES;
        end
      end
      MDU_RUN: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = MDU_IDLE;
          done    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a <= 32'd0;
      op_b <= 32'd0;
      op_q <= 3'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      if (accept) begin
        op_a <= a;
        op_b <= b;
        op_q <= op;
      end
      if (done) begin
        if (wr_ok) {hi, lo} <= res;
      end else if (state == MDU_IDLE) begin
        // start owns the cycle; any mthi/mtlo strobe with it is dropped
        if (start) begin
          if (op == MDU_SHL) {hi, lo} <= {hi, lo} << b[4:0];
        end else begin
          if (hi_we) hi <= a;
          if (lo_we) lo <= a;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized self-checking bench for mdu_unit.
// Reference model computes HI/LO with 64-bit integer arithmetic.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  always #5 clk = ~clk;

  mdu_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .hi_we(hi_we), .lo_we(lo_we), .a(a), .b(b),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, hi, hi_m);
    check({tag, "_lo"}, lo, lo_m);
  endtask

  // Expected {HI,LO} after the op; wr=0 means registers stay as they are.
  task automatic ref_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output logic [63:0] r,
                        output bit wr);
    longint sx, sy, q, m;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    wr = 1'b1;
    r  = 64'd0;
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = ux * uy;
      3'd2: begin
        if (y == 0) wr = 1'b0;
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) wr = 1'b0;
        else r = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endtask

  task automatic run_long(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit strobes);
    logic [63:0] e;
    bit wr;
    int n;
    n = (o >= 3'd2) ? 10 : 5;
    ref_op(o, x, y, e, wr);
    op = o; a = x; b = y; start = 1'b1;
    hi_we = strobes; lo_we = strobes;
    #1;
    check("stall_at_start", stall_req, 1'b1);
    check("busy_at_start", busy, 1'b0);
    cyc();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom;
      hi_we = 1'($urandom_range(0, 1));
      lo_we = 1'($urandom_range(0, 1));
      #1;
      check("busy_run", busy, 1'b1);
      check("stall_run", stall_req, 1'b1);
      check_regs("hold_run");
      cyc();
    end
    hi_we = 1'b0; lo_we = 1'b0;
    if (wr) {hi_m, lo_m} = e;
    #1;
    check("busy_done", busy, 1'b0);
    check("stall_done", stall_req, 1'b0);
    check_regs("result");
  endtask

  task automatic run_shl(input logic [31:0] y);
    op = 3'd4; b = y; a = $urandom; start = 1'b1;
    hi_we = 1'($urandom_range(0, 1)); lo_we = 1'($urandom_range(0, 1));
    #1;
    check("shl_stall", stall_req, 1'b1);
    cyc();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    {hi_m, lo_m} = {hi_m, lo_m} * (64'd1 << y[4:0]);
    check("shl_busy", busy, 1'b0);
    check_regs("shl");
  endtask

  task automatic run_mt(input bit hw, input bit lw, input logic [31:0] x);
    a = x; hi_we = hw; lo_we = lw; start = 1'b0;
    cyc();
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) hi_m = x;
    if (lw) lo_m = x;
    check("mt_busy", busy, 1'b0);
    check_regs("mt");
  endtask

  task automatic run_nop(input logic [2:0] o);
    op = o; a = $urandom; b = $urandom; start = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1;
    cyc();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("nop_busy", busy, 1'b0);
    check_regs("nop");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0;
    hi_we = 1'b0; lo_we = 1'b0; a = 32'd0; b = 32'd0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall_req, 1'b0);
    check_regs("rst");
    cyc(); cyc();
    reset = 1'b1;

    run_long(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1);
    check("mult_hi_const", hi, 32'hFFFFFFFF);
    check("mult_lo_const", lo, 32'hFFFFFFFA);
    run_long(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("multu_hi_const", hi, 32'h00000002);
    check("multu_lo_const", lo, 32'hFFFFFFFA);
    run_long(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo_const", lo, 32'hFFFFFFFD);
    check("div_hi_const", hi, 32'hFFFFFFFF);
    run_mt(1'b1, 1'b0, 32'd1);
    run_mt(1'b0, 1'b1, 32'd2);
    run_long(3'd3, 32'd7, 32'd0, 1'b0);
    check("divu0_hi_const", hi, 32'd1);
    check("divu0_lo_const", lo, 32'd2);
    run_long(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("ovf_lo_const", lo, 32'h80000000);
    check("ovf_hi_const", hi, 32'd0);
    run_mt(1'b1, 1'b0, 32'h1);
    run_mt(1'b0, 1'b1, 32'h80000000);
    run_shl(32'd4);
    check("shl_hi_const", hi, 32'h18);
    check("shl_lo_const", lo, 32'h0);
    run_mt(1'b1, 1'b1, 32'hA5A5_5A5A);
    run_nop(3'd5);
    run_nop(3'd7);

    op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    #2 reset = 1'b0;
    #1;
    hi_m = 32'd0; lo_m = 32'd0;
    check("abort_busy", busy, 1'b0);
    check_regs("abort");
    for (int i = 0; i < 12; i++) cyc();
    check("abort_idle", busy, 1'b0);
    check_regs("abort_late");
    reset = 1'b1;
    run_long(3'd0, $urandom, $urandom, 1'b0);

    for (int i = 0; i < 150; i++) begin
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: run_long(3'(k), $urandom, $urandom, 1'($urandom_range(0, 1)));
        4: run_long(3'($urandom_range(2, 3)), $urandom, 32'($urandom_range(0, 3)), 1'b0);
        5: run_shl($urandom);
        6: run_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        7: run_nop(3'($urandom_range(5, 7)));
        8: run_long(3'd2, 32'($urandom_range(0, 1) ? 32'h80000000 : $urandom), 32'hFFFFFFFF, 1'b0);
        default: run_long(3'd0, $urandom, 32'hFFFFFFFF, 1'b0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: start  input  1  E-stage mult/multu/div/divu/shl issue strobe; one-cycle pulse.
REQ-004 SHALL: op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=shl; codes 5-7 are no-ops.
REQ-005 SHALL: hi_we  input  1  mthi strobe; writes a to HI.
REQ-006 SHALL: lo_we  input  1  mtlo strobe; writes a to LO.
REQ-007 SHALL: a  input  32  forwarded rs operand.
REQ-008 SHALL: b  input  32  forwarded rt operand.
REQ-009 SHALL: busy  output  1  high while a multi-cycle operation is in progress.
REQ-010 SHALL: stall_req  output  1  start OR busy; combinational; consumed by the hazard unit for MDU-class instructions.
REQ-011 SHALL: hi  output  32  registered architectural HI.
REQ-012 SHALL: lo  output  32  registered architectural LO.

Function
REQ-013 SHALL: two-state FSM, IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-014 SHALL: IDLE with start and op in 0..3 latches a, b and op, loads cnt (mult/multu=5, div/divu=10), and enters RUN next edge.
REQ-015 SHALL: in RUN, cnt decrements each cycle; busy=1 for exactly 5 cycles (mult) or 10 cycles (div), starting the cycle after start.
REQ-016 SHALL: HI/LO update on the edge that returns RUN to IDLE, from the latched operands only; later changes on a/b have no effect.
REQ-017 SHALL: mult: {HI,LO}=signed a*b (64-bit); multu: unsigned 64-bit product.
REQ-018 SHALL: div: LO=signed quotient truncated toward zero, HI=remainder with the sign of the dividend; divu: unsigned quotient and remainder.
REQ-019 SHALL: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-020 SHALL: a zero divisor (div/divu) runs the full 10 cycles and leaves HI and LO unchanged.
REQ-021 SHALL: shl (start, op=4) completes in one edge with busy staying 0: {HI,LO} = {HI,LO} << b[4:0]; bits shifted out are discarded.
REQ-022 SHALL: start with op 5-7 causes no state change.
REQ-023 SHALL: start, hi_we and lo_we are ignored while busy=1; the hazard unit guarantees none are issued then.
REQ-024 SHALL: in IDLE, start takes priority over hi_we/lo_we in the same cycle; the strobes are dropped.
REQ-025 SHALL: hi_we and lo_we together in IDLE write a to both HI and LO.
REQ-026 SHALL: hi and lo hold their previous values throughout RUN; no partial results are visible.

Reset
REQ-027 SHALL: reset low asynchronously forces IDLE, cnt=0, busy=0, hi=0, lo=0, and latched operands to 0.
REQ-028 SHALL: reset asserted during RUN abandons the operation; no result is ever written.
REQ-029 SHALL: after reset deasserts, the first start is accepted on the first rising edge.

Structure
REQ-030 SHALL: a shared package mdu_pkg holds the op-code constants (MDU_MULT..MDU_SHL) and the latency constants MULT_CYCLES=5 and DIV_CYCLES=10; the controller uses the same package.
REQ-031 SHALL: the block is a single module with no sub-modules; the behavioural operators * / % are acceptable for the result computation.

Verification
REQ-032 SHALL: mult a=0xFFFFFFFE(-2), b=3 -> busy high cycles 1-5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 SHALL: div a=-7, b=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu a=7, b=0 with HI=1, LO=2 beforehand -> HI=1, LO=2 after 10 cycles.
REQ-034 SHALL: mthi 0x1 then mtlo 0x80000000, then shl b=4 -> same cycle busy=0; next edge HI=0x18, LO=0.
REQ-035 SHALL: start div and drive reset low at cycle 4 -> busy=0, hi=lo=0 immediately; no update afterwards.
REQ-036 SHALL: start mult with hi_we=1 in the same cycle -> hi_we is ignored; an hi_we pulse during busy leaves HI unchanged; stall_req matches start|busy every cycle.
